// File: rtl/br_predictor.sv
// br_predictor: front-end branch predictor.
//
// A bimodal table of 2-bit saturating counters (BHT) combined with a
// direct-mapped branch target buffer (BTB). It gives a zero-latency
// taken/target prediction for the fetch PC. It is trained by branches
// resolved in the branch FU, through a one-entry update stage (U), so a
// resolved branch reaches the tables one edge after it is sampled.
//
// Ports
//   clk, rst        clock (rising edge) / asynchronous active-high reset
//   if_valid_i      fetch lookup request valid
//   if_pc_i         fetch PC to predict
//   pred_taken_o    predicted taken
//   pred_target_o   predicted next PC (BTB target if taken, else PC + 4)
//   pred_hit_o      BTB tag hit for if_pc_i
//   ex_valid_i      resolved-branch pulse from the branch FU
//   ex_pc_i         PC of the resolved branch
//   ex_cond_i       1 = conditional, 0 = unconditional
//   ex_taken_i      resolved direction
//   ex_target_i     resolved taken target
//   upd_busy_o      stage U holds a pending table write
module br_predictor #(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int BTB_TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  input  logic [63:0] if_pc_i,
  output logic        pred_taken_o,
  output logic [63:0] pred_target_o,
  output logic        pred_hit_o,
  input  logic        ex_valid_i,
  input  logic [63:0] ex_pc_i,
  input  logic        ex_cond_i,
  input  logic        ex_taken_i,
  input  logic [63:0] ex_target_i,
  output logic        upd_busy_o
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  // Highest PC bit that takes part in indexing or tagging.
  localparam int PC_HI = (BHT_IDX_W > BTB_IDX_W + BTB_TAG_W) ?
                         BHT_IDX_W + 1 : BTB_IDX_W + BTB_TAG_W + 1;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [1:0]           bht        [BHT_N];
  logic                 btb_valid  [BTB_N];
  logic                 btb_uncond [BTB_N];
  logic [BTB_TAG_W-1:0] btb_tag    [BTB_N];
  logic [63:0]          btb_target [BTB_N];

  // ---------------------------------------------------------------------
  // Lookup path (combinational, reads the tables as they stand this cycle,
  // so a write landing on the coming edge is not yet visible)
  // ---------------------------------------------------------------------
  logic [BHT_IDX_W-1:0] if_bht_idx;
  logic [BTB_IDX_W-1:0] if_btb_idx;
  logic [BTB_TAG_W-1:0] if_tag;

  assign if_bht_idx = if_pc_i[BHT_IDX_W+1:2];
  assign if_btb_idx = if_pc_i[BTB_IDX_W+1:2];
  assign if_tag     = if_pc_i[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];

  always_comb begin
    pred_hit_o    = if_valid_i & btb_valid[if_btb_idx] &
                    (btb_tag[if_btb_idx] == if_tag);
    // Unconditional entries predict taken regardless of the counter.
    pred_taken_o  = pred_hit_o &
                    (btb_uncond[if_btb_idx] | bht[if_bht_idx][1]);
    pred_target_o = pred_taken_o ? btb_target[if_btb_idx] : if_pc_i + 64'd4;
  end

  // ---------------------------------------------------------------------
  // Update stage U
  // ---------------------------------------------------------------------
  logic                 u_valid;
  logic                 u_cond;
  logic                 u_taken;
  logic [BHT_IDX_W-1:0] u_bht_idx;
  logic [BTB_IDX_W-1:0] u_btb_idx;
  logic [BTB_TAG_W-1:0] u_tag;
  logic [63:0]          u_target;

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples its inputs from before the edge; blocking (=) here
  // would make the result depend on process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) u_valid <= 1'b0;
    else     u_valid <= ex_valid_i;
  end

  // Payload needs no reset: it is only consumed while u_valid is set.
  always_ff @(posedge clk) begin
    if (ex_valid_i) begin
      u_cond    <= ex_cond_i;
      u_taken   <= ex_taken_i;
      u_bht_idx <= ex_pc_i[BHT_IDX_W+1:2];
      u_btb_idx <= ex_pc_i[BTB_IDX_W+1:2];
      u_tag     <= ex_pc_i[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
      u_target  <= ex_target_i;
    end
  end

  assign upd_busy_o = u_valid;

  // Counter read-modify-write: stage U reads the table after any earlier
  // write has landed, so back-to-back updates to one index accumulate.
  logic [1:0] u_cnt;
  logic [1:0] u_cnt_next;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    u_cnt      = bht[u_bht_idx];
    u_cnt_next = u_cnt;
    if (u_taken) begin
      if (u_cnt != 2'd3) u_cnt_next = u_cnt + 2'd1;
    end else begin
      if (u_cnt != 2'd0) u_cnt_next = u_cnt - 2'd1;
    end
  end

  // NOTE: only the BHT counters and the BTB valid bits are reset -- those
  // are the bits whose reset value is architecturally visible. The BTB
  // tag/target/uncond arrays are plain memory and stay unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (u_valid && u_cond) begin
      bht[u_bht_idx] <= u_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (u_valid && u_taken) begin
      btb_valid[u_btb_idx] <= 1'b1;
    end
  end

  // Taken branches overwrite the indexed entry outright; not-taken ones
  // never touch the BTB, even on a tag hit.
  always_ff @(posedge clk) begin
    if (u_valid && u_taken) begin
      btb_tag[u_btb_idx]    <= u_tag;
      btb_target[u_btb_idx] <= u_target;
      btb_uncond[u_btb_idx] <= ~u_cond;
    end
  end

  // PC bits outside the index/tag fields are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ex_pc_i[63:PC_HI+1], ex_pc_i[1:0]};

endmodule

// File: tb/tb_br_predictor.sv
// Scoreboard bench for br_predictor: the stimulus process pushes the
// expected lookup response whenever it issues a probed lookup, and a
// monitor pops and compares at the falling edge of that cycle.
module tb_br_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [63:0] if_pc_i;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;
  logic        pred_hit_o;
  logic        ex_valid_i;
  logic [63:0] ex_pc_i;
  logic        ex_cond_i;
  logic        ex_taken_i;
  logic [63:0] ex_target_i;
  logic        upd_busy_o;

  br_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid_i   (if_valid_i),
    .if_pc_i      (if_pc_i),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o),
    .pred_hit_o   (pred_hit_o),
    .ex_valid_i   (ex_valid_i),
    .ex_pc_i      (ex_pc_i),
    .ex_cond_i    (ex_cond_i),
    .ex_taken_i   (ex_taken_i),
    .ex_target_i  (ex_target_i),
    .upd_busy_o   (upd_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [63:0] target;
    logic        busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  probe = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;
  logic  stim_done = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: compares whenever the stimulus marks a probed lookup cycle.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".hit"},    {63'd0, pred_hit_o},   {63'd0, e.hit});
        check({nm, ".taken"},  {63'd0, pred_taken_o}, {63'd0, e.taken});
        check({nm, ".target"}, pred_target_o,          e.target);
        check({nm, ".busy"},   {63'd0, upd_busy_o},   {63'd0, e.busy});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle resolved-branch pulse.
  task automatic update(input logic [63:0] pc, input logic cond,
                        input logic taken, input logic [63:0] target);
    ex_valid_i  = 1'b1;
    ex_pc_i     = pc;
    ex_cond_i   = cond;
    ex_taken_i  = taken;
    ex_target_i = target;
    tick();
    ex_valid_i  = 1'b0;
  endtask

  // Probed lookup occupying one cycle; expectation pushed at issue.
  task automatic lookup(input string nm, input logic v, input logic [63:0] pc,
                        input logic hit, input logic taken,
                        input logic [63:0] target, input logic busy);
    exp_t e;
    e.hit = hit; e.taken = taken; e.target = target; e.busy = busy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if_valid_i = v;
    if_pc_i    = pc;
    probe      = 1'b1;
    tick();
    probe      = 1'b0;
    if_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; if_valid_i = 1'b0; if_pc_i = '0;
    ex_valid_i = 1'b0; ex_pc_i = '0; ex_cond_i = 1'b0;
    ex_taken_i = 1'b0; ex_target_i = '0;
    #1;
    do_reset();

    // 1. Reset state, plus PC+4 wrap in 64-bit arithmetic.
    lookup("t1_reset", 1, 64'h1000, 0, 0, 64'h1004, 0);
    lookup("t1_wrap",  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 0);

    // 2. Train 0x1000 taken -> 0x2000; not visible one cycle later.
    update(64'h1000, 1, 1, 64'h2000);
    lookup("t2_early", 1, 64'h1000, 0, 0, 64'h1004, 1);
    lookup("t2_hit",   1, 64'h1000, 1, 1, 64'h2000, 0);
    lookup("t2_noval", 0, 64'h1000, 0, 0, 64'h1004, 0);

    // 3. Saturation: 2 -> 3 (x3 taken), -> 1 (x2 not taken).
    update(64'h1000, 1, 1, 64'h2000);
    update(64'h1000, 1, 1, 64'h2000);
    update(64'h1000, 1, 1, 64'h2000);
    tick();
    lookup("t3_sat3", 1, 64'h1000, 1, 1, 64'h2000, 0);
    update(64'h1000, 1, 0, 64'h0);
    update(64'h1000, 1, 0, 64'h0);
    tick();
    lookup("t3_cnt1", 1, 64'h1000, 1, 0, 64'h1004, 0);
    update(64'h1000, 1, 0, 64'h0);   // -> 0
    update(64'h1000, 1, 0, 64'h0);   // stays 0
    update(64'h1000, 1, 1, 64'h2000); // -> 1
    tick();
    lookup("t3_floor", 1, 64'h1000, 1, 0, 64'h1004, 0);
    update(64'h1000, 1, 1, 64'h2000); // -> 2
    tick();
    lookup("t3_cnt2", 1, 64'h1000, 1, 1, 64'h2000, 0);

    // 4. Unconditional branch leaves the BHT counter (1) untouched.
    do_reset();
    update(64'h3000, 0, 1, 64'h40);
    tick();
    lookup("t4_uncond", 1, 64'h3000, 1, 1, 64'h40, 0);
    lookup("t4_other_tag", 1, 64'h1000, 0, 0, 64'h1004, 0);
    update(64'h3000, 1, 1, 64'h80);  // counter 1 -> 2, entry now cond
    tick();
    lookup("t4_cond_t", 1, 64'h3000, 1, 1, 64'h80, 0);
    update(64'h3000, 1, 0, 64'h0);   // counter 2 -> 1
    tick();
    lookup("t4_cond_nt", 1, 64'h3000, 1, 0, 64'h3004, 0);

    // 5. Aliasing in the BTB (same index, different tag).
    do_reset();
    update(64'h1000, 1, 1, 64'h2000);
    update(64'h1040, 1, 1, 64'h5000);
    tick();
    lookup("t5_evicted", 1, 64'h1000, 0, 0, 64'h1004, 0);
    lookup("t5_new",     1, 64'h1040, 1, 1, 64'h5000, 0);

    // 6. Reset while a write is pending discards it.
    do_reset();
    update(64'h1000, 1, 1, 64'h2000);
    check("t6_busy_pre_rst", {63'd0, upd_busy_o}, 64'd1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    lookup("t6_after_rst", 1, 64'h1000, 0, 0, 64'h1004, 0);
    lookup("t6_no_write",  1, 64'h1000, 0, 0, 64'h1004, 0);
    update(64'h1000, 1, 1, 64'h2000); // counter 1 -> 2
    tick();
    lookup("t6_retrain", 1, 64'h1000, 1, 1, 64'h2000, 0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
